// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit constants and the single-digit step with carry/borrow.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam bcd_digit_t BCD_ZERO      = 4'd0;

    typedef struct packed {
        logic       c;
        bcd_digit_t d;
    } bcd_step_t;

    // c flags a carry (9->0 going up) or a borrow (0->9 going down).
    function automatic bcd_step_t bcd_step(input bcd_digit_t d, input logic up);
        return up ? ((d == BCD_MAX_DIGIT) ? {1'b1, BCD_ZERO} : {1'b0, d + 4'd1})
                  : ((d == BCD_ZERO) ? {1'b1, BCD_MAX_DIGIT} : {1'b0, d - 4'd1});
    endfunction

endpackage

// File: rtl/bcd_counter_2digit_tick_gen.sv
// tick_gen: prescaler that strobes tick for one cycle every CLK_FREQ/TICK_HZ enabled cycles.
module tick_gen #(
    parameter int CLK_FREQ = 12000000,
    parameter int TICK_HZ  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int W   = $clog2(DIV);

    logic [W-1:0] cnt_q;

    // Strobe is combinational so the consumer registers it on the same edge the prescaler wraps.
    assign tick = en && (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt_q <= '0;
        else if (tick)
            cnt_q <= '0;
        else if (en)
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/bcd_counter_2digit.sv
// bcd_counter_2digit: two-digit BCD up/down counter with prescaler and wrap at MAX_VAL.
// Optional parallel load under BCD_CNT_LOAD_EN.
module bcd_counter_2digit
    import bcd_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int TICK_HZ  = 1,
    parameter int MAX_VAL  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       up_dn,
    input  logic       clr,
`ifdef BCD_CNT_LOAD_EN
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
`endif
    output logic [3:0] seg_data_1,
    output logic [3:0] seg_data_2,
    output logic       tick,
    output logic       wrap
);

    localparam bcd_digit_t MAX_T = bcd_digit_t'(MAX_VAL / 10);
    localparam bcd_digit_t MAX_U = bcd_digit_t'(MAX_VAL % 10);

    bcd_digit_t tens_q, units_q, tens_d, units_d;
    logic       tick_q, wrap_q, wrap_d, stb, load_ok;
    bcd_step_t  u;

`ifdef BCD_CNT_LOAD_EN
    assign load_ok = load && (load_tens <= BCD_MAX_DIGIT) && (load_units <= BCD_MAX_DIGIT)
                     && (int'(load_tens) * 10 + int'(load_units) <= MAX_VAL);
`else
    assign load_ok = 1'b0;
`endif

    tick_gen #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (clr || load_ok),
        .tick (stb)
    );

    always_comb begin
        u       = bcd_step(units_q, up_dn);
        wrap_d  = up_dn ? (tens_q == MAX_T && units_q == MAX_U)
                        : (tens_q == BCD_ZERO && units_q == BCD_ZERO);
        tens_d  = wrap_d ? (up_dn ? BCD_ZERO : MAX_T)
                         : (u.c ? (up_dn ? tens_q + 4'd1 : tens_q - 4'd1) : tens_q);
        units_d = wrap_d ? (up_dn ? BCD_ZERO : MAX_U) : u.d;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens_q  <= BCD_ZERO;
            units_q <= BCD_ZERO;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (load_ok) begin
`ifdef BCD_CNT_LOAD_EN
            tens_q  <= load_tens;
            units_q <= load_units;
`endif
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            tick_q <= stb;
            wrap_q <= stb && wrap_d;
            if (stb) begin
                tens_q  <= tens_d;
                units_q <= units_d;
            end
        end
    end

    assign seg_data_1 = tens_q;
    assign seg_data_2 = units_q;
    assign tick       = tick_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// tb_bcd_counter_2digit: two counters (MAX_VAL 99 and 59, DIV=10) checked each cycle against a modular-arithmetic model.
module tb_bcd_counter_2digit;

    localparam int DIV = 10;

    logic clk = 1'b0, rst = 1'b1, run = 1'b0, up_dn = 1'b1, clr = 1'b0;
    logic [3:0] t0, u0, t1, u1;
    logic tk0, wr0, tk1, wr1;
    int checks = 0, failures = 0;
    int mv[2];
    int mp = 0;
    bit mt[2], mw[2];
    bit en_cmp = 0;
    int n;

    always #5 clk = ~clk;

    bcd_counter_2digit #(.CLK_FREQ(10), .TICK_HZ(1), .MAX_VAL(99)) dut0 (
        .clk(clk), .rst(rst), .run(run), .up_dn(up_dn), .clr(clr),
        .seg_data_1(t0), .seg_data_2(u0), .tick(tk0), .wrap(wr0));

    bcd_counter_2digit #(.CLK_FREQ(10), .TICK_HZ(1), .MAX_VAL(59)) dut1 (
        .clk(clk), .rst(rst), .run(run), .up_dn(up_dn), .clr(clr),
        .seg_data_1(t1), .seg_data_2(u1), .tick(tk1), .wrap(wr1));

    function automatic int maxv(int i);
        return (i == 0) ? 99 : 59;
    endfunction

    // Model: count value as an integer modulo MAX_VAL+1, stepping every DIV run-cycles.
    always @(posedge clk) begin
        if (rst || clr) begin
            mp <= 0;
            for (int i = 0; i < 2; i++) begin
                mv[i] <= 0;
                mt[i] <= 0;
                mw[i] <= 0;
            end
        end else begin
            if (run) mp <= (mp == DIV - 1) ? 0 : mp + 1;
            for (int i = 0; i < 2; i++) begin
                mt[i] <= run && mp == DIV - 1;
                mw[i] <= run && mp == DIV - 1 && mv[i] == (up_dn ? maxv(i) : 0);
                if (run && mp == DIV - 1)
                    mv[i] <= up_dn ? ((mv[i] == maxv(i)) ? 0 : mv[i] + 1)
                                   : ((mv[i] == 0) ? maxv(i) : mv[i] - 1);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en_cmp) begin
            chk("d0_tens", {4'b0, t0}, 8'(mv[0] / 10));
            chk("d0_units", {4'b0, u0}, 8'(mv[0] % 10));
            chk("d0_tick", {7'b0, tk0}, {7'b0, mt[0]});
            chk("d0_wrap", {7'b0, wr0}, {7'b0, mw[0]});
            chk("d1_tens", {4'b0, t1}, 8'(mv[1] / 10));
            chk("d1_units", {4'b0, u1}, 8'(mv[1] % 10));
            chk("d1_tick", {7'b0, tk1}, {7'b0, mt[1]});
            chk("d1_wrap", {7'b0, wr1}, {7'b0, mw[1]});
        end
    end

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!tk0 && cnt < 40);
        if (tk0 !== 1'b1) chk("tick_timeout", {7'b0, tk0}, 8'd1);
    endtask

    task automatic steps(input int k);
        int c;
        repeat (k) wait_tick(c);
    endtask

    initial begin
        int seen;
        rst = 1'b1; run = 1'b1; up_dn = 1'b1;
        repeat (3) @(negedge clk);
        en_cmp = 1;
        chk("rst_tens", {4'b0, t0}, 8'd0);
        chk("rst_units", {4'b0, u0}, 8'd0);
        chk("rst_tick", {7'b0, tk0}, 8'd0);
        chk("rst_wrap", {7'b0, wr0}, 8'd0);
        rst = 1'b0;
        wait_tick(n);
        chk("first_interval", 8'(n), 8'd10);
        chk("val_01", {t0, u0}, 8'h01);
        steps(8);
        wait_tick(n);
        chk("interval_10", 8'(n), 8'd10);
        chk("val_10_carry", {t0, u0}, 8'h10);
        steps(88);
        chk("val_98", {t0, u0}, 8'h98);
        chk("model_98", 8'(mv[0]), 8'd98);
        steps(1);
        chk("val_99", {t0, u0}, 8'h99);
        chk("wrap_99", {7'b0, wr0}, 8'd0);
        steps(1);
        chk("val_00_up", {t0, u0}, 8'h00);
        chk("wrap_up", {7'b0, wr0}, 8'd1);
        chk("d1_val_40", {t1, u1}, 8'h40);
        @(negedge clk);
        chk("wrap_one_cycle", {7'b0, wr0}, 8'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_val", {t1, u1}, 8'h00);
        up_dn = 1'b0;
        wait_tick(n);
        chk("down_interval", 8'(n), 8'd10);
        chk("down_wrap_99", {t0, u0}, 8'h99);
        chk("down_wrap_59", {t1, u1}, 8'h59);
        chk("down_wrap_flag", {7'b0, wr1}, 8'd1);
        steps(1);
        chk("down_58", {t1, u1}, 8'h58);
        steps(8);
        chk("down_50", {t1, u1}, 8'h50);
        steps(1);
        chk("borrow_49", {t1, u1}, 8'h49);
        chk("model_49", 8'(mv[1]), 8'd49);
        repeat (9) @(negedge clk);
        run = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (tk0 || tk1) seen++;
        end
        chk("frozen_ticks", 8'(seen), 8'd0);
        chk("frozen_val", {t1, u1}, 8'h49);
        run = 1'b1;
        @(negedge clk);
        chk("resume_tick", {7'b0, tk1}, 8'd1);
        chk("resume_val", {t1, u1}, 8'h48);
        up_dn = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        steps(37);
        chk("val_37", {t0, u0}, 8'h37);
        repeat (9) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_strobe_val", {t0, u0}, 8'h00);
        chk("clr_strobe_tick", {7'b0, tk0}, 8'd0);
        wait_tick(n);
        chk("clr_interval", 8'(n), 8'd10);
        chk("clr_next_01", {t0, u0}, 8'h01);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_strobe_val", {t0, u0}, 8'h00);
        chk("rst_strobe_tick", {7'b0, tk0}, 8'd0);
        wait_tick(n);
        chk("rst_interval", 8'(n), 8'd10);
        chk("rst_next_01", {t0, u0}, 8'h01);
        en_cmp = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
